fib_arbiter: RTL and testbench
==============================

# fib_arbiter

Shared-access controller for the iterative Fibonacci datapath. Up to N requesters each ask for F(k) for their own index k. The block arbitrates them round-robin, sequences one internal iterative core (start, iterate, done) and returns the result to the granted requester. It sits between client blocks and the single Fibonacci engine, so only one computation runs at a time.

## Interface
- W, 32: result width; arithmetic is modulo 2^W.
- N, 4: number of requesters (≥2).
- IW, 7: index width; k ranges over 0..2^IW−1.

- clk  in  1  clock, rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-low.
- en  in  1  global enable; 0 freezes all state, and gnt/done stay 0.
- req  in  N  per-requester request, level.
- idx  in  N*IW  per-requester index k; slice i = idx[i*IW +: IW].
- gnt  out  N  one-hot, one-cycle pulse: request accepted.
- done  out  N  one-hot, one-cycle pulse: y is valid for that requester.
- y  out  W  result F(k); held from the done pulse until the next done.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: if en and req≠0, select the winner, latch owner and k=idx[owner], load the core (a=0, b=1, cnt=0), go to RUN. The winner gets a gnt pulse in the first RUN cycle.
  - RUN: each enabled cycle, if cnt==k, latch y=a and go to DONE. Otherwise a←b, b←a+b (truncated to W), cnt←cnt+1.
  - DONE: done[owner]=1 for one cycle; pointer←(owner+1) mod N; go to IDLE.
- Arbitration:
  - Round-robin, searching from the pointer upward with wrap.
  - Pointer resets to 0.
  - Only the winner is affected; other requests stay pending.
- Request rules:
  - req is sampled only in IDLE.
  - A requester must hold req until it sees gnt, and must drop req by the cycle after gnt.
  - req dropped before grant is a withdrawal; no gnt or done is issued for it.
  - req still high when the FSM returns to IDLE is a new request.
- idx is sampled only at grant; later changes have no effect.
- Overflow wraps silently: y = F(k) mod 2^W.
- The cnt width is IW+1, so cnt never wraps for k = 2^IW−1.

## Timing
- Reset (rst=0 at a clock edge) forces state=IDLE, pointer=0, gnt=0, done=0, busy=0, y=0, and clears the core.
- Reset mid-RUN or in DONE aborts the computation. No done is emitted and y returns to 0.
- All outputs are registered.
- With request sampled at edge of cycle c (en=1 throughout):
  - gnt is high in cycle c+1.
  - done and the new y appear in cycle c+k+2.
  - IDLE is reached in cycle c+k+3.
  - Back-to-back service: the next grant appears in cycle c+k+4.
- Throughput: one result per k+3 cycles.
- en=0 stalls any state in place and extends latency by exactly the stalled cycles.
  - gnt/done are withheld during the stall and emitted once en returns.
  - y is unaffected by the stall.
- k=0: RUN lasts one cycle; y=0. k=1: y=1.

## Structure
- Package fib_pkg:
  - FSM state localparams (IDLE, RUN, DONE), 2-bit encoding.
  - Default values for W, N, IW.
- Sub-module fib_core:
  - Holds a, b, cnt and k.
  - Ports: clk, rst, en, start, k, result, finished.
  - fib_arbiter keeps the FSM, round-robin pointer, owner register and output registers.

## Test plan
- Reset: hold rst=0 for 3 cycles with req=4'b1111 → gnt=0, done=0, busy=0, y=0 throughout; no grant in the first post-reset cycle in which req is sampled before release.
- Single request: req[2]=1, idx[2]=10, sampled cycle c → gnt=4'b0100 at c+1, done=4'b0100 and y=55 at c+12. Repeat with k=0 (y=0, done at c+2) and k=1 (y=1, done at c+3).
- Round-robin: all four requesters request from reset with k=3 → grants in order 0,1,2,3, each done with y=2, spaced 6 cycles apart. Then re-request 0 and 3 only → grant order 0,3.
- Overflow: W=32, k=47 → y=2971215073; k=48 → y=512559680 (wrapped); k=127 completes with done at c+129.
- Stall: en=0 for 5 cycles mid-RUN with k=10 → done at c+17, y=55, no spurious pulses during the stall.
- Abort: rst=0 for one cycle mid-RUN → no done for the aborted request, y=0, pointer=0. The next request completes normally.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci arbiter: default sizes and FSM state encoding.
package fib_pkg;

    localparam int unsigned FIB_W  = 32;
    localparam int unsigned FIB_N  = 4;
    localparam int unsigned FIB_IW = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fib_core.sv
// Iterative Fibonacci engine: loaded with k on start, steps once per enabled cycle until cnt==k.
module fib_core
    import fib_pkg::*;
#(
    parameter int unsigned W  = FIB_W,
    parameter int unsigned IW = FIB_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic [IW-1:0] k,
    output logic [W-1:0]  result,
    output logic          finished
);

    // One extra bit so the counter can reach 2^IW-1 without wrapping.
    localparam int unsigned CW = IW + 1;

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] k_q, k_d;
    logic          fin_q, fin_d;

    // fin_q tracks cnt==k for the register values it sits beside.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        fin_d = fin_q;
        if (start) begin
            a_d   = '0;
            b_d   = W'(1);
            cnt_d = '0;
            k_d   = k;
            fin_d = (k == '0);
        end else if (!fin_q) begin
            a_d   = b_q;
            b_d   = a_q + b_q;
            cnt_d = cnt_q + CW'(1);
            fin_d = (cnt_d == CW'(k_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            k_q   <= '0;
            fin_q <= 1'b1;
        end else if (en) begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;
            fin_q <= fin_d;
        end
    end

    assign result   = a_q;
    assign finished = fin_q;

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin front end that shares one fib_core among N requesters and returns F(k) mod 2^W.
module fib_arbiter
    import fib_pkg::*;
#(
    parameter int unsigned W  = FIB_W,
    parameter int unsigned N  = FIB_N,
    parameter int unsigned IW = FIB_IW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N*IW-1:0] idx,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [W-1:0]    y,
    output logic            busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  done_q, done_d;
    logic [W-1:0]  y_q, y_d;
    logic          busy_q, busy_d;

    logic          win_found;
    logic [PW-1:0] win;
    logic [IW-1:0] win_k;
    int unsigned   pos;

    logic          start_c;
    logic [W-1:0]  core_res;
    logic          core_fin;

    // Round-robin search starting at the pointer, wrapping at N.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        win_k     = '0;
        pos       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = (int'(ptr_q) + i) % N;
            if (!win_found && req[pos]) begin
                win_found = 1'b1;
                win       = PW'(pos);
                win_k     = idx[pos*IW +: IW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        done_d  = '0;
        y_d     = y_q;
        start_c = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        owner_d    = win;
                        gnt_d[win] = 1'b1;
                        start_c    = 1'b1;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (core_fin) begin
                        y_d             = core_res;
                        done_d[owner_q] = 1'b1;
                        state_d         = DONE;
                    end
                end
                DONE: begin
                    ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

    fib_core #(
        .W  (W),
        .IW (IW)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start_c),
        .k        (win_k),
        .result   (core_res),
        .finished (core_fin)
    );

    assign gnt  = gnt_q;
    assign done = done_q;
    assign y    = y_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Self-checking bench for fib_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_fib_arbiter;

    localparam int N  = 4;
    localparam int IW = 7;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req;
    logic [N*IW-1:0] idx;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [W-1:0]    y;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fib_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .req  (req),
        .idx  (idx),
        .gnt  (gnt),
        .done (done),
        .y    (y),
        .busy (busy)
    );

    // Fibonacci from its definition, truncated to W bits.
    function automatic logic [W-1:0] fib_ref(input int k);
        logic [W-1:0] f0, f1, t;
        f0 = '0;
        f1 = W'(1);
        for (int i = 0; i < k; i++) begin
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
        end
        return f0;
    endfunction

    function automatic int rr_pick(input int p, input logic [N-1:0] pend);
        for (int o = 0; o < N; o++)
            if (pend[(p + o) % N]) return (p + o) % N;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idx(input int r, input int k);
        idx[r*IW +: IW] = IW'(k);
    endtask

    task automatic wait_gnt(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (gnt != '0) return;
        end
        n = -1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (done != '0) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        req = '1;
        idx = '0;
        for (int r = 0; r < N; r++) set_idx(r, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (gnt !== '0 || done !== '0 || busy !== 1'b0 || y !== '0) begin
                n_bad++;
                $display("FAIL reset[%0d]: gnt=%b done=%b busy=%b y=%0d, required 0 0 0 0", i, gnt, done, busy, y);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] pend, exp;
        int ptr, w, n, last_g;
        pend   = 4'b1111;
        ptr    = 0;
        last_g = -1;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                pend = 4'b1001;
                req  = pend;
            end
            while (pend != '0) begin
                w   = rr_pick(ptr, pend);
                exp = 4'(1) << w;
                wait_gnt(40, n);
                n_cmp++;
                if (gnt !== exp) begin
                    n_bad++;
                    $display("FAIL rr_gnt: got %b, required %b", gnt, exp);
                end
                if (last_g >= 0) begin
                    n_cmp++;
                    if (cyc - last_g != 6) begin
                        n_bad++;
                        $display("FAIL rr_spacing: got %0d cycles, required 6", cyc - last_g);
                    end
                end
                last_g  = cyc;
                pend[w] = 1'b0;
                req[w]  = 1'b0;
                wait_done(40, n);
                n_cmp++;
                if (n != 4 || done !== exp || y !== 32'd2) begin
                    n_bad++;
                    $display("FAIL rr_done: lat=%0d done=%b y=%0d, required lat=4 done=%b y=2", n, done, y, exp);
                end
                ptr = (w + 1) % N;
            end
        end
        tick();
    endtask

    task automatic test_single();
        int ks[3] = '{10, 0, 1};
        int r, k, n;
        logic [W-1:0] ey;
        logic [N-1:0] exp;
        for (int t = 0; t < 7; t++) begin
            r   = (t < 3) ? 2 : int'($urandom_range(0, N - 1));
            k   = (t < 3) ? ks[t] : int'($urandom_range(0, 60));
            ey  = (t == 0) ? 32'd55 : (t == 1) ? 32'd0 : (t == 2) ? 32'd1 : fib_ref(k);
            exp = 4'(1) << r;
            set_idx(r, k);
            req = exp;
            wait_gnt(5, n);
            n_cmp++;
            if (n != 1 || gnt !== exp) begin
                n_bad++;
                $display("FAIL single_gnt k=%0d: lat=%0d gnt=%b, required lat=1 gnt=%b", k, n, gnt, exp);
            end
            req = '0;
            set_idx(r, int'($urandom_range(0, 127)));
            wait_done(200, n);
            n_cmp++;
            if (n != k + 1 || done !== exp || y !== ey) begin
                n_bad++;
                $display("FAIL single_done k=%0d: lat=%0d done=%b y=%0d, required lat=%0d done=%b y=%0d", k, n, done, y, k + 1, exp, ey);
            end
            tick();
            n_cmp++;
            if (busy !== 1'b0 || done !== '0 || y !== ey) begin
                n_bad++;
                $display("FAIL single_hold k=%0d: busy=%b done=%b y=%0d, required 0 0 %0d", k, busy, done, y, ey);
            end
        end
    endtask

    task automatic test_overflow();
        int ks[3] = '{47, 48, 127};
        logic [W-1:0] eys[3];
        int n;
        eys[0] = 32'd2971215073;
        eys[1] = 32'd512559680;
        eys[2] = fib_ref(127);
        for (int t = 0; t < 3; t++) begin
            set_idx(3, ks[t]);
            req = 4'b1000;
            wait_gnt(5, n);
            n_cmp++;
            if (n != 1 || gnt !== 4'b1000) begin
                n_bad++;
                $display("FAIL ovf_gnt k=%0d: lat=%0d gnt=%b, required lat=1 gnt=1000", ks[t], n, gnt);
            end
            req = '0;
            wait_done(300, n);
            n_cmp++;
            if (n != ks[t] + 1 || done !== 4'b1000 || y !== eys[t]) begin
                n_bad++;
                $display("FAIL ovf_done k=%0d: lat=%0d done=%b y=%0d, required lat=%0d done=1000 y=%0d", ks[t], n, done, y, ks[t] + 1, eys[t]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int n, total;
        logic [W-1:0] y0;
        set_idx(1, 10);
        req = 4'b0010;
        wait_gnt(5, n);
        req = '0;
        y0  = y;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (gnt !== '0 || done !== '0 || busy !== 1'b1 || y !== y0) begin
                n_bad++;
                $display("FAIL stall[%0d]: gnt=%b done=%b busy=%b y=%0d, required 0 0 1 %0d", i, gnt, done, busy, y, y0);
            end
        end
        en = 1'b1;
        wait_done(40, n);
        total = (n < 0) ? -1 : 8 + n;
        n_cmp++;
        if (total != 16 || done !== 4'b0010 || y !== 32'd55) begin
            n_bad++;
            $display("FAIL stall_done: lat=%0d done=%b y=%0d, required lat=16 done=0010 y=55", total, done, y);
        end
        tick();
    endtask

    task automatic test_abort();
        int n, spurious;
        set_idx(1, 2);
        req = 4'b0010;
        wait_gnt(5, n);
        req = '0;
        wait_done(20, n);
        tick();
        set_idx(2, 20);
        req = 4'b0100;
        wait_gnt(5, n);
        req = '0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || y !== '0 || done !== '0 || gnt !== '0) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b y=%0d done=%b gnt=%b, required 0 0 0 0", busy, y, done, gnt);
        end
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done != '0 || gnt != '0) spurious++;
        end
        n_cmp++;
        if (spurious != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: %0d pulse cycles, required 0", spurious);
        end
        set_idx(1, 5);
        set_idx(2, 6);
        req = 4'b0110;
        wait_gnt(5, n);
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL abort_ptr: gnt=%b, required 0010", gnt);
        end
        req = '0;
        wait_done(20, n);
        n_cmp++;
        if (n != 6 || done !== 4'b0010 || y !== 32'd5) begin
            n_bad++;
            $display("FAIL abort_next: lat=%0d done=%b y=%0d, required lat=6 done=0010 y=5", n, done, y);
        end
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt != '0 || done != '0) spurious++;
        end
        n_cmp++;
        if (spurious != 0) begin
            n_bad++;
            $display("FAIL withdraw: %0d pulse cycles, required 0", spurious);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend, add, exp;
        int kk[N];
        int ptr, w, n, cnt;
        logic e;
        req = '0;
        rst = 1'b0;
        tick();
        rst  = 1'b1;
        pend = '0;
        ptr  = 0;
        for (int rnd = 0; rnd < 25; rnd++) begin
            add = N'($urandom_range(0, 15));
            if ((pend | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
            for (int r = 0; r < N; r++) begin
                if (add[r] && !pend[r]) begin
                    kk[r] = int'($urandom_range(0, 50));
                    set_idx(r, kk[r]);
                end
            end
            pend = pend | add;
            req  = pend;
            w    = rr_pick(ptr, pend);
            exp  = 4'(1) << w;
            n    = 0;
            do begin
                en = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end while (gnt == '0 && n < 60);
            n_cmp++;
            if (gnt !== exp) begin
                n_bad++;
                $display("FAIL rand_gnt[%0d]: gnt=%b, required %b", rnd, gnt, exp);
            end
            pend[w] = 1'b0;
            req     = pend;
            set_idx(w, int'($urandom_range(0, 127)));
            cnt = 0;
            n   = 0;
            do begin
                e  = ($urandom_range(0, 4) != 0);
                en = e;
                tick();
                n++;
                if (e) cnt++;
            end while (done == '0 && n < 400);
            n_cmp++;
            if (done !== exp || y !== fib_ref(kk[w]) || cnt != kk[w] + 1) begin
                n_bad++;
                $display("FAIL rand_done[%0d]: done=%b y=%0d en_cycles=%0d, required done=%b y=%0d en_cycles=%0d",
                         rnd, done, y, cnt, exp, fib_ref(kk[w]), kk[w] + 1);
            end
            ptr = (w + 1) % N;
            en  = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_overflow();
        test_stall();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
